// File: rtl/pc_pipe_pkg.sv
// Shared types and constants for the elastic program-counter pipeline.
package pc_pipe_pkg;

  localparam int unsigned RV32I_INC = 4;
  localparam int unsigned RVC_INC   = 2;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } state_e;

  function automatic int unsigned count_width(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pc_pipe_if.sv
// Handshake bundle for pc_pipe: upstream PC offer, downstream PC/successor, flush and occupancy.
interface pc_pipe_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CW   = 3
);

  logic            io_in_valid;
  logic            io_in_ready;
  logic [XLEN-1:0] io_in_pc;
  logic            io_flush;
  logic            io_out_valid;
  logic            io_out_ready;
  logic [XLEN-1:0] io_out_pc;
  logic [XLEN-1:0] io_out_pc4;
  logic [CW-1:0]   io_count;

  modport slave (
    input  io_in_valid, io_in_pc, io_flush, io_out_ready,
    output io_in_ready, io_out_valid, io_out_pc, io_out_pc4, io_count
  );

  modport master (
    output io_in_valid, io_in_pc, io_flush, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_pc, io_out_pc4, io_count
  );

endinterface

// File: rtl/pc_pipe_stage.sv
// One two-entry skid buffer carrying {pc, pc4}; ready and valid come straight from the state register.
module pc_pipe_stage
  import pc_pipe_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     INC      = RV32I_INC
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{pc: RESET_PC, pc4: RESET_PC + XLEN'(INC)};

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   push, pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the data registers get a defined reset value too, since pc/pc4 are visible outputs while empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_ENTRY;
      skid_q  <= RESET_ENTRY;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // NOTE: every comb output takes a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (push) begin
          state_d = BUSY;
          main_d  = '{pc: in_pc, pc4: in_pc4};
        end
        BUSY: begin
          if (push && pop) begin
            main_d = '{pc: in_pc, pc4: in_pc4};
          end else if (push) begin
            state_d = FULL;
            skid_d  = '{pc: in_pc, pc4: in_pc4};
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    out_pc    = main_q.pc;
    out_pc4   = main_q.pc4;
  end

endmodule

// File: rtl/pc_pipe.sv
// Elastic PC pipeline: STAGES cascaded skid buffers, pc4 formed once at entry, end-to-end occupancy counter.
module pc_pipe
  import pc_pipe_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     STAGES   = 2,
  parameter int unsigned     INC      = RV32I_INC,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic        clock,
  input  logic        reset,
  pc_pipe_if.slave    bus
);

  localparam int unsigned CW = count_width(STAGES);

  logic            stg_valid [STAGES+1];
  logic            stg_ready [STAGES+1];
  logic [XLEN-1:0] stg_pc    [STAGES+1];
  logic [XLEN-1:0] stg_pc4   [STAGES+1];

  logic [CW-1:0] count_q, count_d;
  logic          in_push, out_pop;

  assign stg_valid[0]      = bus.io_in_valid;
  assign stg_pc[0]         = bus.io_in_pc;
  assign stg_pc4[0]        = bus.io_in_pc + XLEN'(INC);
  assign stg_ready[STAGES] = bus.io_out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pc_pipe_stage #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC),
      .INC      (INC)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .flush     (bus.io_flush),
      .in_valid  (stg_valid[i]),
      .in_ready  (stg_ready[i]),
      .in_pc     (stg_pc[i]),
      .in_pc4    (stg_pc4[i]),
      .out_valid (stg_valid[i+1]),
      .out_ready (stg_ready[i+1]),
      .out_pc    (stg_pc[i+1]),
      .out_pc4   (stg_pc4[i+1])
    );
  end

  assign bus.io_in_ready  = stg_ready[0];
  assign bus.io_out_valid = stg_valid[STAGES];
  assign bus.io_out_pc    = stg_pc[STAGES];
  assign bus.io_out_pc4   = stg_pc4[STAGES];
  assign bus.io_count     = count_q;

  assign in_push = bus.io_in_valid && stg_ready[0];
  assign out_pop = stg_valid[STAGES] && bus.io_out_ready;

  // Occupancy only changes at the two ends; internal stage-to-stage moves keep it constant.
  always_comb begin
    count_d = count_q;
    if (bus.io_flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(in_push) - CW'(out_pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
